// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0]  MEM_BYTE = 2'b00;
  localparam logic [1:0]  MEM_HALF = 2'b01;
  localparam logic [1:0]  MEM_WORD = 2'b10;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Natural alignment check for a data access of the given size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_WORD: mis = (addr_lo != 2'b00);
      MEM_HALF: mis = addr_lo[0];
      MEM_BYTE: mis = 1'b0;
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_wait_timer.sv
// Handshake wait counter shared by the fetch and data-access phases.
module core_wait_timer #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_r;

  // Count consecutive un-acked request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (en) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // This un-acked cycle is the MAX-th one.
  assign expired = en & (cnt_r == 8'(MAX - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with PC, handshakes and sticky trap.
// Optional alignment trapping is enabled by defining CORE_MISALIGN_TRAP_EN.
import core_pkg::*;

module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        n_inst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic [4:0]  rd_num,
  input  logic        br_taken,
  input  logic [31:0] target,
  input  logic [1:0]  mem_size,
  input  logic [1:0]  mem_addr_lo,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        trap,
  output logic [2:0]  state
);

  state_e      state_r;
  logic [31:0] pc_r;
  logic        imem_req_r;
  logic        dmem_req_r;
  logic        dmem_we_r;
  logic        rf_we_r;
  logic        trap_r;

  logic        wait_s;
  logic        tmo_s;
  logic        taken_s;
  logic        wb_we_s;
  logic        mem_mis_s;
  logic        xfer_mis_s;
  logic [31:0] next_pc_s;

  // A request cycle without ack advances the timer; any other cycle clears it.
  assign wait_s = ((state_r == ST_FETCH) & imem_req_r & ~imem_ack) |
                  ((state_r == ST_MEM)   & dmem_req_r & ~dmem_ack);

  core_wait_timer #(.MAX(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~wait_s),
    .en      (wait_s),
    .expired (tmo_s)
  );

  assign taken_s   = is_jump | (is_branch & br_taken);
  assign next_pc_s = taken_s ? {target[31:2], 2'b00} : pc_r + PC_INC;

`ifdef CORE_MISALIGN_TRAP_EN
  assign mem_mis_s  = (is_load | is_store) & misaligned(mem_size, mem_addr_lo);
  assign xfer_mis_s = taken_s & (target[1:0] != 2'b00);
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{mem_size, mem_addr_lo, target[1:0]};
  assign mem_mis_s    = 1'b0;
  assign xfer_mis_s   = 1'b0;
`endif

  // Write-back enable, evaluated on entry to WB from the stable decoder outputs.
  assign wb_we_s = ~is_store & ~is_branch & (rd_num != 5'd0) & ~xfer_mis_s;

  // Sequencer state, PC and registered handshake/enable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      rf_we_r    <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_req_r && imem_ack) begin
            state_r    <= ST_DECODE;
            imem_req_r <= 1'b0;
          end else if (tmo_s) begin
            state_r    <= ST_TRAP;
            imem_req_r <= 1'b0;
            trap_r     <= 1'b1;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (n_inst) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if ((is_load || is_store) && mem_mis_s) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end else if (is_load || is_store) begin
            state_r    <= ST_MEM;
            dmem_req_r <= 1'b1;
            dmem_we_r  <= is_store;
          end else begin
            state_r <= ST_WB;
            rf_we_r <= wb_we_s;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_r    <= ST_WB;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            rf_we_r    <= wb_we_s;
          end else if (tmo_s) begin
            state_r    <= ST_TRAP;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            trap_r     <= 1'b1;
          end else begin
            dmem_req_r <= 1'b1;
          end
        end
        ST_WB: begin
          rf_we_r <= 1'b0;
          if (xfer_mis_s) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end else begin
            state_r    <= ST_FETCH;
            pc_r       <= next_pc_s;
            imem_req_r <= 1'b1;
          end
        end
        ST_TRAP: begin
          imem_req_r <= 1'b0;
          dmem_req_r <= 1'b0;
          dmem_we_r  <= 1'b0;
          rf_we_r    <= 1'b0;
          trap_r     <= 1'b1;
        end
        default: begin
          state_r    <= ST_TRAP;
          imem_req_r <= 1'b0;
          dmem_req_r <= 1'b0;
          dmem_we_r  <= 1'b0;
          rf_we_r    <= 1'b0;
          trap_r     <= 1'b1;
        end
      endcase
    end
  end

  // The IR strobe must coincide with the ack cycle, so it is qualified by the live ack.
  assign ir_we    = (state_r == ST_FETCH) & imem_req_r & imem_ack;
  assign pc       = pc_r;
  assign imem_req = imem_req_r;
  assign dmem_req = dmem_req_r;
  assign dmem_we  = dmem_we_r;
  assign rf_we    = rf_we_r;
  assign trap     = trap_r;
  assign state    = state_r;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl (default build or CORE_MISALIGN_TRAP_EN).
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack, dmem_ack;
  logic        n_inst, is_load, is_store, is_branch, is_jump;
  logic [4:0]  rd_num;
  logic        br_taken;
  logic [31:0] target;
  logic [1:0]  mem_size, mem_addr_lo;
  logic [31:0] pc;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, trap;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .n_inst(n_inst), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .rd_num(rd_num), .br_taken(br_taken), .target(target),
    .mem_size(mem_size), .mem_addr_lo(mem_addr_lo), .pc(pc), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
    .trap(trap), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_op(input logic n, input logic ld, input logic st, input logic br,
                        input logic jp, input logic [4:0] rd, input logic bt,
                        input logic [31:0] tgt, input logic [1:0] sz, input logic [1:0] lo);
    n_inst = n; is_load = ld; is_store = st; is_branch = br; is_jump = jp;
    rd_num = rd; br_taken = bt; target = tgt; mem_size = sz; mem_addr_lo = lo;
  endtask

  // Leaves the bench at the negedge where rst_n was released (idle FETCH cycle follows).
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 2'b10, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from a FETCH request cycle until the next FETCH or TRAP.
  task automatic run_instr(input int delay, output int lat, output int dreq,
                           output int dwe, output int rfw);
    int mc;
    bit done;
    lat = 0; dreq = 0; dwe = 0; rfw = 0; mc = 0; done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      lat++;
      if (dmem_req) dreq++;
      if (dmem_req && dmem_we) dwe++;
      if (rf_we) rfw++;
      if (state == 3'd3) begin
        dmem_ack = (mc >= delay);
        mc++;
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      if (state == 3'd0 || state == 3'd7) done = 1'b1;
    end
    dmem_ack = 1'b0;
    if (!done) check("instr_bound", 32'd0, 32'd1);
  endtask

  int lat, dreq, dwe, rfw, n;
  bit done;

  initial begin
    // Reset values
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_reqs", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    rst_n = 1'b1;

    // 1: ADDI rd=1 with imem_ack always high
    imem_ack = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 2'b10, 2'b00);
    @(negedge clk);
    check("t1_fetch_state", {29'd0, state}, 32'd0);
    check("t1_fetch_req_irwe", {30'd0, imem_req, ir_we}, 32'd3);
    @(negedge clk);
    check("t1_decode", {29'd0, state, imem_req}, 32'd2);
    @(negedge clk);
    check("t1_exec", {29'd0, state}, 32'd2);
    @(negedge clk);
    check("t1_wb", {29'd0, state}, 32'd4);
    check("t1_wb_rfwe", {31'd0, rf_we}, 32'd1);
    check("t1_wb_pc", pc, 32'h0);
    @(negedge clk);
    check("t1_next_fetch", {28'd0, state, rf_we}, 32'd0);
    check("t1_pc", pc, 32'h4);

    // 2: LW rd=5 with ack delayed 3 cycles, then LW and SW with immediate ack
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 32'h0, 2'b10, 2'b00);
    run_instr(3, lat, dreq, dwe, rfw);
    check("t2_lw_dreq", dreq, 32'd4);
    check("t2_lw_dwe", dwe, 32'd0);
    check("t2_lw_rfwe", rfw, 32'd1);
    check("t2_lw_lat", lat, 32'd8);
    check("t2_lw_pc", pc, 32'h8);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t2_lw_lat0", lat, 32'd5);
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 32'h0, 2'b10, 2'b00);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t2_sw_lat", lat, 32'd5);
    check("t2_sw_dwe_rfwe", {dwe[15:0], rfw[15:0]}, {16'd1, 16'd0});
    check("t2_sw_pc", pc, 32'h10);

    // 3: branches, jump, PC wrap
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 32'h0000_0100, 2'b10, 2'b00);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t3_beq_t_lat", lat, 32'd4);
    check("t3_beq_t_rfwe", rfw, 32'd0);
    check("t3_beq_t_pc", pc, 32'h100);
    br_taken = 1'b0;
    run_instr(0, lat, dreq, dwe, rfw);
    check("t3_beq_nt_pc", pc, 32'h104);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 32'hFFFF_FFFC, 2'b10, 2'b00);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t3_jal_rfwe", rfw, 32'd1);
    check("t3_jal_pc", pc, 32'hFFFF_FFFC);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 2'b10, 2'b00);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t3_rd0_rfwe", rfw, 32'd0);
    check("t3_wrap_pc", pc, 32'h0);

    // 4a: imem_ack never arrives
    do_reset();
    n = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (state == 3'd7) done = 1'b1;
      else if (state == 3'd0 && imem_req) n++;
    end
    check("t4_wait_cycles", n, 32'd255);
    check("t4_trap", {30'd0, trap, imem_req}, 32'd2);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_sticky", {28'd0, state, trap}, 32'hF);
    check("t4_pc_frozen", pc, 32'h0);

    // 4b: ack on the 255th request cycle wins over the timeout
    do_reset();
    @(negedge clk);
    for (int i = 1; i < 255; i++) @(negedge clk);
    check("t4b_still_fetch", {29'd0, state}, 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    check("t4b_decode", {28'd0, state, trap}, 32'd2);

    // 5a: illegal instruction traps after DECODE
    do_reset();
    imem_ack = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 2'b10, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check("t5_decode", {29'd0, state}, 32'd1);
    @(negedge clk);
    check("t5_trap", {28'd0, state, trap}, 32'hF);
    check("t5_no_enables", {29'd0, imem_req, dmem_req, rf_we}, 32'd0);

    // 5b: reset asserted while a load waits in MEM
    do_reset();
    imem_ack = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 32'h0, 2'b10, 2'b00);
    @(negedge clk);
    run_instr(0, lat, dreq, dwe, rfw);
    check("t5b_pc_before", pc, 32'h4);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 32'h0, 2'b10, 2'b00);
    repeat (3) @(negedge clk);
    check("t5b_in_mem", {30'd0, state == 3'd3, dmem_req}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5b_async_drop", {29'd0, dmem_req, imem_req, rf_we}, 32'd0);
    check("t5b_async_pc", pc, 32'h0);
    check("t5b_async_state", {29'd0, state}, 32'd0);

    // 6: misaligned word store and misaligned jump target
    do_reset();
    imem_ack = 1'b1;
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 2'b10, 2'b10);
    @(negedge clk);
    run_instr(0, lat, dreq, dwe, rfw);
`ifdef CORE_MISALIGN_TRAP_EN
    check("t6_sw_mis_trap", {28'd0, state, trap}, 32'hF);
    check("t6_sw_mis_noreq", dreq, 32'd0);
`else
    check("t6_sw_lat", lat, 32'd5);
    check("t6_sw_dwe", dwe, 32'd1);
    check("t6_sw_pc", pc, 32'h4);
`endif
    do_reset();
    imem_ack = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0000_0503, 2'b10, 2'b00);
    @(negedge clk);
    run_instr(0, lat, dreq, dwe, rfw);
`ifdef CORE_MISALIGN_TRAP_EN
    check("t6_jalr_mis_trap", {28'd0, state, trap}, 32'hF);
    check("t6_jalr_mis_pc", pc, 32'h0);
    check("t6_jalr_mis_rfwe", rfw, 32'd0);
`else
    check("t6_jalr_pc", pc, 32'h500);
    check("t6_jalr_rfwe", rfw, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
